pcie_tx_quiesce: RTL and testbench
==================================

Name: pcie_tx_quiesce

Overview:
- Transmit-side counterpart to the endpoint reset/link-up sequencer.
- Gates the user TX engine's access to the Virtex-5 TRN TX interface according to link state and a host quiesce request.
- On link loss or quiesce, lets the in-flight TLP finish at a packet boundary before halting; aborts after a timeout.
- Sits between the TX DMA engine and the PCIe endpoint core in the clk250 domain.

Parameters:
- UP_DELAY, 16: cycles of continuous link-up before TX is enabled (>=1).
- DRAIN_TIMEOUT, 1024: maximum cycles in DRAIN before a forced abort (>=2).
- TMR_W, 16: width of the shared delay/timeout counter (must hold max(UP_DELAY, DRAIN_TIMEOUT)).

Ports:
- clk250  in  1  250 MHz TRN clock.
- trn_reset_n  in  1  asynchronous active-low reset.
- trn_lnk_up_n  in  1  endpoint link status, low = link up.
- trn_tsof_n  in  1  TX start-of-frame (monitored only).
- trn_teof_n  in  1  TX end-of-frame (monitored only).
- trn_tsrc_rdy_n  in  1  TX source ready (monitored only).
- trn_tdst_rdy_n  in  1  TX destination ready (monitored only).
- quiesce_req  in  1  level; host request to stop TX.
- tx_enable  out  1  TX engine may start a new TLP.
- quiesced  out  1  no TLP in flight and TX disabled.
- drain_abort  out  1  one-cycle pulse when drain times out; TX engine must flush its state.

Behaviour:
- Clock and reset: one clock, clk250. trn_reset_n is asynchronous and active-low.
- Reset values: state=LINK_DOWN, tx_enable=0, quiesced=1, drain_abort=0, in_packet=0, timer=0.
- Registered outputs: all outputs are registered and reflect the state one cycle after a transition.
- Beat accepted: trn_tsrc_rdy_n==0 and trn_tdst_rdy_n==0.
- in_packet tracking:
  - Set on an accepted beat with sof=0 and eof=1 (active-low: SOF asserted, EOF not asserted).
  - Cleared on an accepted beat with eof=0.
  - A single-beat TLP (sof and eof asserted together) leaves in_packet=0.
  - Define in_packet_nxt = the value in_packet takes this cycle.
- States (one-hot):
  - LINK_DOWN: quiesced=1, tx_enable=0. trn_lnk_up_n==0 -> LINK_WAIT, timer<=0.
  - LINK_WAIT: quiesced=1. trn_lnk_up_n==1 -> LINK_DOWN. Otherwise timer++; at timer==UP_DELAY-1 -> ACTIVE if quiesce_req==0, else HALTED.
  - ACTIVE: tx_enable=1, quiesced=0. trn_lnk_up_n==1 or quiesce_req==1 -> DRAIN, timer<=0. A TLP started in the transition cycle is tracked and drained.
  - DRAIN: tx_enable=0, quiesced=0, timer++.
    - If in_packet_nxt==0: go to LINK_DOWN if trn_lnk_up_n==1, else HALTED.
    - Else if timer==DRAIN_TIMEOUT-1: drain_abort=1 for exactly one cycle, in_packet<=0, same destination rule.
    - Packet completion on the timeout cycle takes precedence over the abort; no pulse is emitted.
  - HALTED: quiesced=1, tx_enable=0. trn_lnk_up_n==1 -> LINK_DOWN (takes priority). Else quiesce_req==0 -> ACTIVE.
- Toggling quiesce_req during DRAIN has no effect; the drain completes, then HALTED re-evaluates the request.
- Asynchronous reset mid-packet: immediately returns to reset values; in_packet is discarded.
- Timer does not wrap; it is reset on every state entry that uses it.

Optional Feature:
- Macro: PCIE_TX_QUIESCE_STATS_EN.
- With the macro, adds outputs link_drop_cnt[15:0] and abort_cnt[15:0].
  - link_drop_cnt increments when ACTIVE or DRAIN is exited or redirected because trn_lnk_up_n==1.
  - abort_cnt increments on each drain_abort pulse.
  - Both saturate at 16'hFFFF and reset to 0.
- Without the macro, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package/header: state one-hot encodings (5 bits), UP_DELAY/DRAIN_TIMEOUT defaults, stats counter width.
- Sub-module trn_tx_pkt_tracker: takes the four TRN TX monitor signals and produces in_packet and in_packet_nxt. It is reusable by the RX-side monitor.

Test Plan:
1. Link up at t0 with quiesce_req=0 -> tx_enable rises exactly UP_DELAY+1 cycles later (17 cycles at default); quiesced falls on the same cycle.
2. Link glitch low for 5 cycles (<UP_DELAY) -> returns to LINK_DOWN; tx_enable never asserts.
3. ACTIVE with a 4-beat TLP in flight; quiesce_req=1 at beat 2 -> tx_enable=0 next cycle; HALTED and quiesced=1 one cycle after the EOF beat; quiesce_req=0 -> tx_enable=1 next cycle.
4. DRAIN with trn_tdst_rdy_n held high, DRAIN_TIMEOUT=8 -> single drain_abort pulse 8 cycles after DRAIN entry, then HALTED; abort_cnt=1 with the stats macro.
5. Link drops mid-TLP with the EOF beat accepted 3 cycles later -> LINK_DOWN with no abort; link_drop_cnt=1.
6. Assert trn_reset_n=0 asynchronously mid-TLP in ACTIVE -> outputs return to reset values before the next clk250 edge.

Source files
------------

// File: rtl/pcie_tx_quiesce_pkg.sv
// Shared definitions for the TRN TX quiesce gate: one-hot state encodings and
// default timing parameters.
package pcie_tx_quiesce_pkg;

    typedef enum logic [4:0] {
        LINK_DOWN = 5'b00001,
        LINK_WAIT = 5'b00010,
        ACTIVE    = 5'b00100,
        DRAIN     = 5'b01000,
        HALTED    = 5'b10000
    } tx_state_e;

    localparam int UP_DELAY_DEF      = 16;
    localparam int DRAIN_TIMEOUT_DEF = 1024;
    localparam int STATS_W           = 16;

endpackage

// File: rtl/trn_tx_pkt_tracker.sv
// Follows TLP boundaries on a TRN monitor tap; in_packet_nxt is the value
// in_packet takes at the coming edge (before any external clear).
module trn_tx_pkt_tracker (
    input  logic clk250,
    input  logic trn_reset_n,
    input  logic trn_tsof_n,
    input  logic trn_teof_n,
    input  logic trn_tsrc_rdy_n,
    input  logic trn_tdst_rdy_n,
    input  logic pkt_clr,
    output logic in_packet,
    output logic in_packet_nxt
);

    logic beat;

    // EOF wins over SOF so a single-beat TLP never opens a packet
    always_comb begin
        beat          = ~trn_tsrc_rdy_n & ~trn_tdst_rdy_n;
        in_packet_nxt = in_packet;
        if (beat && !trn_teof_n) begin
            in_packet_nxt = 1'b0;
        end else if (beat && !trn_tsof_n) begin
            in_packet_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk250 or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            in_packet <= 1'b0;
        end else begin
            in_packet <= in_packet_nxt & ~pkt_clr;
        end
    end

endmodule

// File: rtl/pcie_tx_quiesce.sv
// Gates TX DMA access to the TRN TX port by link state and host quiesce, draining
// the open TLP first. Define PCIE_TX_QUIESCE_STATS_EN for link-drop/abort counters.
module pcie_tx_quiesce
    import pcie_tx_quiesce_pkg::*;
#(
    parameter int UP_DELAY      = UP_DELAY_DEF,
    parameter int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF,
    parameter int TMR_W         = 16
) (
    input  logic clk250,
    input  logic trn_reset_n,
    input  logic trn_lnk_up_n,
    input  logic trn_tsof_n,
    input  logic trn_teof_n,
    input  logic trn_tsrc_rdy_n,
    input  logic trn_tdst_rdy_n,
    input  logic quiesce_req,
    output logic tx_enable,
    output logic quiesced,
    output logic drain_abort
`ifdef PCIE_TX_QUIESCE_STATS_EN
    ,
    output logic [STATS_W-1:0] link_drop_cnt,
    output logic [STATS_W-1:0] abort_cnt
`endif
);

    localparam logic [TMR_W-1:0] UP_LAST    = TMR_W'(UP_DELAY - 1);
    localparam logic [TMR_W-1:0] DRAIN_LAST = TMR_W'(DRAIN_TIMEOUT - 1);

    tx_state_e        state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic             abort_nxt;
    logic             in_packet_unused;
    logic             in_packet_nxt;

    trn_tx_pkt_tracker u_pkt_tracker (
        .clk250         (clk250),
        .trn_reset_n    (trn_reset_n),
        .trn_tsof_n     (trn_tsof_n),
        .trn_teof_n     (trn_teof_n),
        .trn_tsrc_rdy_n (trn_tsrc_rdy_n),
        .trn_tdst_rdy_n (trn_tdst_rdy_n),
        .pkt_clr        (abort_nxt),
        .in_packet      (in_packet_unused),
        .in_packet_nxt  (in_packet_nxt)
    );

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        abort_nxt = 1'b0;
        case (state)
            LINK_DOWN: begin
                if (!trn_lnk_up_n) begin
                    state_nxt = LINK_WAIT;
                    timer_nxt = '0;
                end
            end
            LINK_WAIT: begin
                if (trn_lnk_up_n) begin
                    state_nxt = LINK_DOWN;
                end else begin
                    timer_nxt = timer + 1'b1;
                    if (timer == UP_LAST) begin
                        state_nxt = quiesce_req ? HALTED : ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                if (trn_lnk_up_n || quiesce_req) begin
                    state_nxt = DRAIN;
                    timer_nxt = '0;
                end
            end
            DRAIN: begin
                // a packet closing on the timeout cycle is a clean finish, not an abort
                timer_nxt = timer + 1'b1;
                if (!in_packet_nxt || timer == DRAIN_LAST) begin
                    state_nxt = trn_lnk_up_n ? LINK_DOWN : HALTED;
                    abort_nxt = in_packet_nxt;
                end
            end
            HALTED: begin
                if (trn_lnk_up_n) begin
                    state_nxt = LINK_DOWN;
                end else if (!quiesce_req) begin
                    state_nxt = ACTIVE;
                end
            end
            default: state_nxt = LINK_DOWN;
        endcase
    end

    always_ff @(posedge clk250 or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            state       <= LINK_DOWN;
            timer       <= '0;
            tx_enable   <= 1'b0;
            quiesced    <= 1'b1;
            drain_abort <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            tx_enable   <= (state == ACTIVE);
            quiesced    <= (state == LINK_DOWN) || (state == LINK_WAIT) || (state == HALTED);
            drain_abort <= abort_nxt;
        end
    end

`ifdef PCIE_TX_QUIESCE_STATS_EN
    // drop_seen stops a link loss that started the drain being counted again at its exit
    logic drop_seen;
    logic drop_evt;

    assign drop_evt = trn_lnk_up_n &&
                      ((state == ACTIVE && state_nxt == DRAIN) ||
                       (state == DRAIN && state_nxt == LINK_DOWN && !drop_seen));

    always_ff @(posedge clk250 or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            drop_seen     <= 1'b0;
            link_drop_cnt <= '0;
            abort_cnt     <= '0;
        end else begin
            if (state == ACTIVE && state_nxt == DRAIN) begin
                drop_seen <= trn_lnk_up_n;
            end
            if (drop_evt && link_drop_cnt != {STATS_W{1'b1}}) begin
                link_drop_cnt <= link_drop_cnt + 1'b1;
            end
            if (abort_nxt && abort_cnt != {STATS_W{1'b1}}) begin
                abort_cnt <= abort_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pcie_tx_quiesce.sv
// Bench for pcie_tx_quiesce: directed vector table for the corner sequences,
// then randomized TRN/link/quiesce traffic against a behavioural model.
module tb_pcie_tx_quiesce;

    localparam int UPD = 16;
    localparam int DT  = 8;

    localparam logic [3:0] IDLE  = 4'b1111;  // {sof_n, eof_n, src_rdy_n, dst_rdy_n}
    localparam logic [3:0] SOF   = 4'b0100;
    localparam logic [3:0] MID   = 4'b1100;
    localparam logic [3:0] EOF   = 4'b1000;
    localparam logic [3:0] STALL = 4'b1101;

    localparam int M_DOWN = 0, M_WAIT = 1, M_ACT = 2, M_DRAIN = 3, M_HALT = 4;

    logic clk250 = 1'b0;
    always #2 clk250 = ~clk250;

    logic trn_reset_n = 1'b1;
    logic lnk_n = 1'b1, qreq = 1'b0;
    logic sof_n = 1'b1, eof_n = 1'b1, src_n = 1'b1, dst_n = 1'b1;
    logic tx_enable, quiesced, drain_abort;
`ifdef PCIE_TX_QUIESCE_STATS_EN
    logic [15:0] link_drop_cnt, abort_cnt;
`endif

    int errors = 0;
    int checks = 0;

    pcie_tx_quiesce #(.UP_DELAY(UPD), .DRAIN_TIMEOUT(DT), .TMR_W(16)) dut (
        .clk250         (clk250),
        .trn_reset_n    (trn_reset_n),
        .trn_lnk_up_n   (lnk_n),
        .trn_tsof_n     (sof_n),
        .trn_teof_n     (eof_n),
        .trn_tsrc_rdy_n (src_n),
        .trn_tdst_rdy_n (dst_n),
        .quiesce_req    (qreq),
        .tx_enable      (tx_enable),
        .quiesced       (quiesced),
        .drain_abort    (drain_abort)
`ifdef PCIE_TX_QUIESCE_STATS_EN
        ,
        .link_drop_cnt  (link_drop_cnt),
        .abort_cnt      (abort_cnt)
`endif
    );

    typedef struct {
        bit         rst;
        bit         st;
        logic       lnk;
        logic       qr;
        logic [3:0] trn;
        int         cyc;
        logic       tx;
        logic       qs;
        logic       ab;
        int         drops;
        int         aborts;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit rst, logic lnk, logic qr, logic [3:0] trn, int cyc,
                                logic tx, logic qs, logic ab);
        vec_t v;
        v.rst = rst; v.st = 1'b0; v.lnk = lnk; v.qr = qr; v.trn = trn; v.cyc = cyc;
        v.tx = tx; v.qs = qs; v.ab = ab; v.drops = 0; v.aborts = 0;
        vecs.push_back(v);
    endfunction

    function automatic void add_st(int drops, int aborts);
        vec_t v;
        v.rst = 1'b0; v.st = 1'b1; v.lnk = 1'b0; v.qr = 1'b0; v.trn = IDLE; v.cyc = 0;
        v.tx = 1'b0; v.qs = 1'b0; v.ab = 1'b0; v.drops = drops; v.aborts = aborts;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk250);
        #1;
    endtask

    // Behavioural reference: mode, cycle counter and packet-open flag
    int m_mode, m_tmr, m_pkt, m_tx, m_q, m_ab;

    task automatic model_reset();
        m_mode = M_DOWN; m_tmr = 0; m_pkt = 0; m_tx = 0; m_q = 1; m_ab = 0;
    endtask

    task automatic model_step();
        bit beat;
        int nxt_pkt;
        beat    = !src_n && !dst_n;
        nxt_pkt = m_pkt;
        if (beat && !eof_n) nxt_pkt = 0;
        else if (beat && !sof_n) nxt_pkt = 1;
        m_tx = (m_mode == M_ACT) ? 1 : 0;
        m_q  = (m_mode == M_DOWN || m_mode == M_WAIT || m_mode == M_HALT) ? 1 : 0;
        m_ab = 0;
        case (m_mode)
            M_DOWN: if (!lnk_n) begin m_mode = M_WAIT; m_tmr = 0; end
            M_WAIT: begin
                if (lnk_n) m_mode = M_DOWN;
                else begin
                    m_tmr++;
                    if (m_tmr == UPD) m_mode = qreq ? M_HALT : M_ACT;
                end
            end
            M_ACT: if (lnk_n || qreq) begin m_mode = M_DRAIN; m_tmr = 0; end
            M_DRAIN: begin
                m_tmr++;
                if (nxt_pkt == 0 || m_tmr == DT) begin
                    if (nxt_pkt != 0) begin m_ab = 1; nxt_pkt = 0; end
                    m_mode = lnk_n ? M_DOWN : M_HALT;
                end
            end
            default: begin
                if (lnk_n) m_mode = M_DOWN;
                else if (!qreq) m_mode = M_ACT;
            end
        endcase
        m_pkt = nxt_pkt;
    endtask

    initial begin
        vec_t v;
        bit stall;

        // reset, then a short link glitch that must not enable TX
        add(1, 1, 0, IDLE,  2, 0, 1, 0);
        add(0, 0, 0, IDLE,  5, 0, 1, 0);
        add(0, 1, 0, IDLE,  3, 0, 1, 0);
        // stable link: tx_enable rises UP_DELAY+1 edges after first link-up edge
        add(0, 0, 0, IDLE, 17, 0, 1, 0);
        add(0, 0, 0, IDLE,  1, 1, 0, 0);
        // 4-beat TLP, quiesce at beat 2, resume
        add(0, 0, 0, SOF,   1, 1, 0, 0);
        add(0, 0, 1, MID,   1, 1, 0, 0);
        add(0, 0, 1, MID,   1, 0, 0, 0);
        add(0, 0, 1, EOF,   1, 0, 0, 0);
        add(0, 0, 1, IDLE,  4, 0, 1, 0);
        add(0, 0, 0, IDLE,  1, 0, 1, 0);
        add(0, 0, 0, IDLE,  1, 1, 0, 0);
        // destination stalled through the whole drain -> abort 8 edges after entry
        add(0, 0, 0, SOF,   1, 1, 0, 0);
        add(0, 0, 1, STALL, 1, 1, 0, 0);
        add(0, 0, 1, STALL, 7, 0, 0, 0);
        add(0, 0, 1, STALL, 1, 0, 0, 1);
        add(0, 0, 1, IDLE,  2, 0, 1, 0);
        add_st(0, 1);
        add(0, 0, 0, IDLE,  1, 0, 1, 0);
        add(0, 0, 0, IDLE,  1, 1, 0, 0);
        // EOF on the timeout cycle completes cleanly
        add(0, 0, 0, SOF,   1, 1, 0, 0);
        add(0, 0, 1, STALL, 1, 1, 0, 0);
        add(0, 0, 1, STALL, 7, 0, 0, 0);
        add(0, 0, 1, EOF,   1, 0, 0, 0);
        add(0, 0, 1, IDLE,  1, 0, 1, 0);
        add_st(0, 1);
        add(0, 0, 0, IDLE,  1, 0, 1, 0);
        add(0, 0, 0, IDLE,  1, 1, 0, 0);
        // link drop mid-TLP, EOF three edges later
        add(0, 0, 0, SOF,   1, 1, 0, 0);
        add(0, 1, 0, MID,   1, 1, 0, 0);
        add(0, 1, 0, MID,   2, 0, 0, 0);
        add(0, 1, 0, EOF,   1, 0, 0, 0);
        add(0, 1, 0, IDLE,  2, 0, 1, 0);
        add_st(1, 1);
        // async reset mid-TLP; the open packet must be forgotten
        add(0, 0, 0, IDLE, 17, 0, 1, 0);
        add(0, 0, 0, IDLE,  1, 1, 0, 0);
        add(0, 0, 0, SOF,   1, 1, 0, 0);
        add(1, 0, 0, IDLE, 17, 0, 1, 0);
        add(0, 0, 0, IDLE,  1, 1, 0, 0);
        add(0, 0, 1, IDLE,  1, 1, 0, 0);
        add(0, 0, 1, IDLE,  1, 0, 0, 0);
        add(0, 0, 1, IDLE,  1, 0, 1, 0);
        add_st(0, 0);

        tick();
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (v.st) begin
`ifdef PCIE_TX_QUIESCE_STATS_EN
                check("link_drop_cnt", i, link_drop_cnt, 16'(v.drops));
                check("abort_cnt", i, abort_cnt, 16'(v.aborts));
`endif
                continue;
            end
            lnk_n = v.lnk;
            qreq  = v.qr;
            {sof_n, eof_n, src_n, dst_n} = v.trn;
            if (v.rst) begin
                trn_reset_n = 1'b0;
                #1;
                check("rst_tx_enable", i, tx_enable, 1'b0);
                check("rst_quiesced", i, quiesced, 1'b1);
                check("rst_drain_abort", i, drain_abort, 1'b0);
                tick();
                trn_reset_n = 1'b1;
            end
            for (int c = 0; c < v.cyc; c++) begin
                tick();
                check("tx_enable", i, tx_enable, v.tx);
                check("quiesced", i, quiesced, v.qs);
                check("drain_abort", i, drain_abort, v.ab);
            end
        end

        // randomized traffic against the model
        trn_reset_n = 1'b0;
        model_reset();
        lnk_n = 1'b0; qreq = 1'b0; stall = 1'b0;
        {sof_n, eof_n, src_n, dst_n} = IDLE;
        tick();
        trn_reset_n = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(39) == 0) lnk_n = ~lnk_n;
            if ($urandom_range(24) == 0) qreq = ~qreq;
            if ($urandom_range(19) == 0) stall = ~stall;
            src_n = ($urandom_range(2) == 0);
            dst_n = stall ? 1'b1 : ($urandom_range(3) == 0);
            sof_n = ($urandom_range(3) != 0);
            eof_n = ($urandom_range(3) != 0);
            tick();
            model_step();
            check("rnd_tx_enable", c, tx_enable, 16'(m_tx));
            check("rnd_quiesced", c, quiesced, 16'(m_q));
            check("rnd_drain_abort", c, drain_abort, 16'(m_ab));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
